// File: rtl/seg7_capture.sv
// seg7_capture: 7-segment bus monitor that debounces, decodes and queues stable glyph changes.
// Optional feature: define SEG7_CAPTURE_DP_EN to include the decimal point in capture and output.
module seg7_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ena,
   input  logic [6:0]                   segments_in,
   input  logic                         dp_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [3:0]                   out_digit,
   output logic                         out_invalid,
   output logic                         out_dp,
   output logic                         overflow,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(STABLE_CYCLES);
`ifdef SEG7_CAPTURE_DP_EN
   localparam int SW = 8;
   localparam int EW = 6;
`else
   localparam int SW = 7;
   localparam int EW = 5;
`endif
   typedef enum logic {SETTLE, HOLD} state_t;
   state_t          r_state, w_state_nxt;
   logic [SW-1:0]   w_sample, r_seg_q, r_last;
   logic [FW-1:0]   r_flt_cnt, w_flt_cnt_nxt;
   logic            w_commit, w_push_req, w_push, w_pop, w_full;
   logic [4:0]      w_dec;
   logic [EW-1:0]   w_entry, w_head;
   logic [EW-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr, r_rd;
   logic [CW-1:0]   r_cnt;
   logic            r_ovf;

   // Returns {invalid, digit}; anything outside the 16 glyphs is flagged invalid with digit 0.
   function automatic logic [4:0] f_decode(input logic [6:0] s);
      case (s)
         7'h3F: return 5'h00;
         7'h06: return 5'h01;
         7'h5B: return 5'h02;
         7'h4F: return 5'h03;
         7'h66: return 5'h04;
         7'h6D: return 5'h05;
         7'h7D: return 5'h06;
         7'h07: return 5'h07;
         7'h7F: return 5'h08;
         7'h6F: return 5'h09;
         7'h77: return 5'h0A;
         7'h7C: return 5'h0B;
         7'h39: return 5'h0C;
         7'h5E: return 5'h0D;
         7'h79: return 5'h0E;
         7'h71: return 5'h0F;
         default: return 5'h10;
      endcase
   endfunction

`ifdef SEG7_CAPTURE_DP_EN
   assign w_sample = {dp_in, segments_in};
   assign w_entry  = {r_seg_q[7], w_dec};
   assign out_dp   = out_valid & w_head[5];
`else
   logic w_unused_dp;
   assign w_unused_dp = dp_in;
   assign w_sample    = segments_in;
   assign w_entry     = w_dec;
   assign out_dp      = 1'b0;
`endif

   assign w_dec       = f_decode(r_seg_q[6:0]);
   assign w_head      = r_mem[r_rd];
   assign out_valid   = r_cnt != '0;
   assign out_digit   = out_valid ? w_head[3:0] : 4'd0;
   assign out_invalid = out_valid & w_head[4];
   assign overflow    = r_ovf;
   assign fifo_count  = r_cnt;
   assign w_pop       = out_valid & out_ready;
   assign w_full      = r_cnt == CW'(FIFO_DEPTH);
   // A blank commit only moves last-committed; it never occupies a FIFO slot.
   assign w_push_req  = w_commit & (r_seg_q != '0);
   assign w_push      = w_push_req & (~w_full | w_pop);

   // Filter next state: count stable samples, commit once per new stable pattern.
   always_comb begin
      w_state_nxt   = r_state;
      w_flt_cnt_nxt = r_flt_cnt;
      w_commit      = 1'b0;
      if (ena) begin
         if (w_sample != r_seg_q) begin
            w_state_nxt   = SETTLE;
            w_flt_cnt_nxt = '0;
         end else if (r_state == SETTLE) begin
            if (r_flt_cnt == FW'(STABLE_CYCLES - 2)) begin
               w_state_nxt   = HOLD;
               w_flt_cnt_nxt = '0;
               w_commit      = r_seg_q != r_last;
            end else begin
               w_flt_cnt_nxt = r_flt_cnt + FW'(1);
            end
         end
      end
   end

   // Filter registers: sampled bus, stability counter, state and last committed pattern.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= SETTLE;
         r_flt_cnt <= '0;
         r_seg_q   <= '0;
         r_last    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_flt_cnt <= w_flt_cnt_nxt;
         if (ena) r_seg_q <= w_sample;
         if (w_commit) r_last <= r_seg_q;
      end
   end

   // FIFO storage; contents need no reset because the count gates every output.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= w_entry;
   end

   // FIFO pointers, occupancy and sticky overflow on a dropped commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
         if (w_push_req & ~w_push) r_ovf <= 1'b1;
      end
   end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and random stimulus against a run-length/queue model of seg7_capture.
module tb_seg7_capture;
   logic       clk = 1'b0;
   logic       rst, ena, dp_in, out_ready;
   logic [6:0] segments_in;
   logic       out_valid, out_invalid, out_dp, overflow;
   logic [3:0] out_digit;
   logic [2:0] fifo_count;
   int checks = 0;
   int errors = 0;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [6:0] m_cur, m_last;
   int         m_run;
   logic       m_ovf;
   logic [4:0] mq[$];

   seg7_capture #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .ena(ena), .segments_in(segments_in), .dp_in(dp_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
      .out_invalid(out_invalid), .out_dp(out_dp), .overflow(overflow), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] ref_decode(input logic [6:0] s);
      for (int i = 0; i < 16; i++) if (glyph[i] == s) return {1'b0, 4'(i)};
      return 5'h10;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic v;
      v = mq.size() > 0;
      chk({tag, ".valid"}, out_valid, v);
      chk({tag, ".digit"}, out_digit, v ? mq[0][3:0] : 4'd0);
      chk({tag, ".invalid"}, out_invalid, v ? mq[0][4] : 1'b0);
      chk({tag, ".count"}, fifo_count, mq.size());
      chk({tag, ".overflow"}, overflow, m_ovf);
      chk({tag, ".dp"}, out_dp, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; ena = 1'b0; out_ready = 1'b0; segments_in = 7'h00; dp_in = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      m_cur = 7'h00; m_last = 7'h00; m_run = 1; m_ovf = 1'b0;
      check_model("reset");
   endtask

   task automatic step(input logic [6:0] s, input logic e, input logic r);
      logic pop, commit, full;
      segments_in = s; ena = e; out_ready = r; dp_in = $urandom_range(0, 1);
      pop = r && mq.size() > 0;
      full = mq.size() == 4;
      @(posedge clk);
      commit = 1'b0;
      if (e) begin
         if (s != m_cur) begin
            m_cur = s;
            m_run = 1;
         end else begin
            m_run++;
            if (m_run == 4 && m_cur != m_last) begin
               m_last = m_cur;
               commit = m_cur != 7'h00;
            end
         end
      end
      if (pop) void'(mq.pop_front());
      if (commit) begin
         if (!full || pop) mq.push_back(ref_decode(m_cur));
         else m_ovf = 1'b1;
      end
      #1;
      check_model("step");
   endtask

   task automatic hold(input logic [6:0] s, input int n, input logic r);
      for (int i = 0; i < n; i++) step(s, 1'b1, r);
   endtask

   initial begin
      logic [6:0] pat;
      int sel;
      do_reset();
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_count", fifo_count, 3'd0);
      // basic capture of digit 3
      hold(7'h4F, 4, 1'b0);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_digit", out_digit, 4'd3);
      chk("t1_invalid", out_invalid, 1'b0);
      chk("t1_count", fifo_count, 3'd1);
      // short glitch rejected
      do_reset();
      hold(7'h06, 3, 1'b0);
      hold(7'h5B, 4, 1'b0);
      chk("t2_count", fifo_count, 3'd1);
      chk("t2_digit", out_digit, 4'd2);
      // blank not queued but re-arms same glyph
      do_reset();
      hold(7'h3F, 4, 1'b0);
      hold(7'h00, 4, 1'b0);
      hold(7'h3F, 4, 1'b0);
      chk("t3_count", fifo_count, 3'd2);
      chk("t3_digit0", out_digit, 4'd0);
      step(7'h3F, 1'b1, 1'b1);
      chk("t3_count_pop", fifo_count, 3'd1);
      chk("t3_digit1", out_digit, 4'd0);
      // illegal pattern
      do_reset();
      hold(7'h01, 4, 1'b0);
      chk("t4_invalid", out_invalid, 1'b1);
      chk("t4_digit", out_digit, 4'd0);
      // overflow and ordered drain
      do_reset();
      hold(7'h06, 4, 1'b0);
      hold(7'h5B, 4, 1'b0);
      hold(7'h4F, 4, 1'b0);
      hold(7'h66, 4, 1'b0);
      hold(7'h6D, 4, 1'b0);
      chk("t5_count", fifo_count, 3'd4);
      chk("t5_overflow", overflow, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         chk("t5_drain", out_digit, i);
         step(7'h6D, 1'b1, 1'b1);
      end
      chk("t5_empty", out_valid, 1'b0);
      hold(7'h3F, 4, 1'b0);
      hold(7'h06, 4, 1'b0);
      hold(7'h5B, 4, 1'b0);
      hold(7'h4F, 4, 1'b0);
      hold(7'h7D, 3, 1'b0);
      step(7'h7D, 1'b1, 1'b1);
      chk("t5_full_pop_count", fifo_count, 3'd4);
      chk("t5_full_pop_head", out_digit, 4'd1);
      // reset mid-settle
      do_reset();
      hold(7'h3F, 4, 1'b0);
      hold(7'h06, 4, 1'b0);
      hold(7'h5B, 2, 1'b0);
      do_reset();
      chk("t6_valid", out_valid, 1'b0);
      chk("t6_count", fifo_count, 3'd0);
      chk("t6_overflow", overflow, 1'b0);
      hold(7'h5B, 4, 1'b0);
      chk("t6_after", out_digit, 4'd2);
      // ena low freezes the filter but pops still happen
      for (int i = 0; i < 8; i++) step(7'h66, 1'b0, 1'b0);
      chk("ena_frozen", fifo_count, 3'd1);
      step(7'h66, 1'b0, 1'b1);
      chk("ena_pop", out_valid, 1'b0);
      // random patterns with random hold lengths, ready and enable
      for (int k = 0; k < 150; k++) begin
         sel = $urandom_range(0, 19);
         pat = (sel < 16) ? glyph[sel] : (sel == 16) ? 7'h00 : 7'($urandom);
         for (int j = $urandom_range(1, 6); j > 0; j--)
            step(pat, $urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
